register_file_wb: RTL and testbench

Eight-entry, 8-bit general-purpose register bank that consumes the writeback stage output and supplies operands to the decode stage. It receives `ans_wb` with its destination index, writes it on the clock edge, and forwards it to the read ports in the same cycle. A pending-write scoreboard is set when decode issues an instruction with a destination and cleared when the matching writeback lands. From the scoreboard it derives a decode `stall` for read-after-write hazards.

---
 rtl/register_file_wb_if.sv | 36 +++
 rtl/register_file_wb.sv | 125 ++++++++++++
 tb/tb_register_file_wb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_wb_if.sv
// Bus bundle between the pipeline (master) and the writeback register bank (slave).
// Carries the writeback port, the two decode read ports, the issue port and the
// hazard/scoreboard status returned to decode.
interface register_file_wb_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   // writeback stage
   logic [DATA_WIDTH-1:0]        ans_wb;
   logic [ADDR_WIDTH-1:0]        rd_wb;
   logic                         wr_en_wb;
   // decode read ports
   logic [ADDR_WIDTH-1:0]        rs_addr;
   logic [ADDR_WIDTH-1:0]        rt_addr;
   logic [DATA_WIDTH-1:0]        rs_data;
   logic [DATA_WIDTH-1:0]        rt_data;
   // decode issue and hazard status
   logic                         issue_valid;
   logic [ADDR_WIDTH-1:0]        issue_rd;
   logic                         stall;
   logic [(2**ADDR_WIDTH)-1:0]   pending;

   modport master (
      output ans_wb, rd_wb, wr_en_wb,
      output rs_addr, rt_addr,
      output issue_valid, issue_rd,
      input  rs_data, rt_data, stall, pending
   );

   modport slave (
      input  ans_wb, rd_wb, wr_en_wb,
      input  rs_addr, rt_addr,
      input  issue_valid, issue_rd,
      output rs_data, rt_data, stall, pending
   );
endinterface

// File: rtl/register_file_wb.sv
// General-purpose register bank fed by the writeback stage.
// - Register 0 is hardwired to zero and never becomes pending.
// - Read ports bypass the in-flight writeback so decode sees it in the same cycle.
// - A pending-write scoreboard tracks destinations of issued instructions and
//   drives a combinational read-after-write stall towards decode.
module register_file_wb #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic               clk,
   input  logic               reset,
   register_file_wb_if.slave  bus
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]  regs_r [NUM_REGS];
   logic [NUM_REGS-1:0]    pending_r;
   logic [NUM_REGS-1:0]    pending_nxt_s;
   logic [NUM_REGS-1:0]    set_mask_s;
   logic [NUM_REGS-1:0]    clr_mask_s;
   logic [DATA_WIDTH-1:0]  rs_data_s;
   logic [DATA_WIDTH-1:0]  rt_data_s;
   logic                   haz_rs_s;
   logic                   haz_rt_s;
   logic                   stall_s;
   logic                   wb_write_s;

   // Operand read with zero register and writeback bypass.
   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  wr_en,
      input logic [ADDR_WIDTH-1:0] wr_addr,
      input logic [DATA_WIDTH-1:0] wr_data,
      input logic [DATA_WIDTH-1:0] stored
   );
      logic [DATA_WIDTH-1:0] value;
      if (addr == '0) begin
         value = '0;
      end else if (wr_en && (wr_addr == addr)) begin
         value = wr_data;
      end else begin
         value = stored;
      end
      return value;
   endfunction

   // A source is hazardous while its register is pending, unless the writeback
   // that resolves it is arriving this very cycle (it is then forwarded).
   function automatic logic source_hazard(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  is_pending,
      input logic                  wr_en,
      input logic [ADDR_WIDTH-1:0] wr_addr
   );
      return (addr != '0) && is_pending && !(wr_en && (wr_addr == addr));
   endfunction

   assign wb_write_s = bus.wr_en_wb && (bus.rd_wb != '0);

   // Register array: writeback lands on the rising edge; r0 is never written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wb_write_s) begin
         regs_r[bus.rd_wb] <= bus.ans_wb;
      end else begin
         regs_r[bus.rd_wb] <= regs_r[bus.rd_wb];
      end
   end

   // Read ports, bypassed from the writeback stage.
   always_comb begin
      rs_data_s = read_port(bus.rs_addr, bus.wr_en_wb, bus.rd_wb, bus.ans_wb,
                            regs_r[bus.rs_addr]);
      rt_data_s = read_port(bus.rt_addr, bus.wr_en_wb, bus.rd_wb, bus.ans_wb,
                            regs_r[bus.rt_addr]);
   end

   // RAW hazard detection for both sources; equal addresses give equal results.
   always_comb begin
      haz_rs_s = source_hazard(bus.rs_addr, pending_r[bus.rs_addr],
                               bus.wr_en_wb, bus.rd_wb);
      haz_rt_s = source_hazard(bus.rt_addr, pending_r[bus.rt_addr],
                               bus.wr_en_wb, bus.rd_wb);
      stall_s  = haz_rs_s || haz_rt_s;
   end

   // Scoreboard next state: accepted issue sets, writeback clears, set wins
   // because the issuing instruction is the newer writer.
   always_comb begin
      set_mask_s = '0;
      clr_mask_s = '0;
      if (bus.issue_valid && !stall_s) begin
         set_mask_s[bus.issue_rd] = 1'b1;
      end else begin
         set_mask_s = '0;
      end
      if (bus.wr_en_wb) begin
         clr_mask_s[bus.rd_wb] = 1'b1;
      end else begin
         clr_mask_s = '0;
      end
      set_mask_s[0] = 1'b0;
      clr_mask_s[0] = 1'b0;
      pending_nxt_s = set_mask_s | (pending_r & ~clr_mask_s);
   end

   // Scoreboard state register; reset drops every in-flight pending bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_r <= '0;
      end else begin
         pending_r <= pending_nxt_s;
      end
   end

   assign bus.rs_data = rs_data_s;
   assign bus.rt_data = rt_data_s;
   assign bus.stall   = stall_s;
   assign bus.pending = pending_r;

endmodule

// File: tb/tb_register_file_wb.sv
// Self-checking bench for register_file_wb: directed scenarios for reset,
// register 0, bypass, hazards and collisions, then randomized traffic checked
// against an array/bitmask reference model of the register bank.
module tb_register_file_wb;
   localparam int DW = 8;
   localparam int AW = 3;
   localparam int NR = 8;

   logic clk = 1'b0;
   logic reset;

   register_file_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   register_file_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] m_regs [NR];
   logic [NR-1:0] m_pend;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference read: what decode should see for a given index right now.
   function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
      if (a == 3'd0) return 8'h00;
      if (bus.wr_en_wb && bus.rd_wb == a) return bus.ans_wb;
      return m_regs[a];
   endfunction

   function automatic logic m_haz(input logic [AW-1:0] a);
      return (a != 3'd0) && m_pend[a] && !(bus.wr_en_wb && bus.rd_wb == a);
   endfunction

   function automatic logic m_stall();
      return m_haz(bus.rs_addr) || m_haz(bus.rt_addr);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
      m_pend = 8'h00;
   endtask

   task automatic drive(input logic wr, input logic [AW-1:0] rd, input logic [DW-1:0] ans,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic iv, input logic [AW-1:0] ird);
      bus.wr_en_wb    = wr;
      bus.rd_wb       = rd;
      bus.ans_wb      = ans;
      bus.rs_addr     = rs;
      bus.rt_addr     = rt;
      bus.issue_valid = iv;
      bus.issue_rd    = ird;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".rs"},      {24'd0, bus.rs_data}, {24'd0, m_read(bus.rs_addr)});
      check({tag, ".rt"},      {24'd0, bus.rt_data}, {24'd0, m_read(bus.rt_addr)});
      check({tag, ".stall"},   {31'd0, bus.stall},   {31'd0, m_stall()});
      check({tag, ".pending"}, {24'd0, bus.pending}, {24'd0, m_pend});
   endtask

   // Advance one rising edge, applying the model's rules to the current inputs.
   task automatic clock_edge();
      logic          st;
      logic [NR-1:0] np;
      st = m_stall();
      np = m_pend;
      if (bus.wr_en_wb && bus.rd_wb != 3'd0) begin
         m_regs[bus.rd_wb] = bus.ans_wb;
         np[bus.rd_wb] = 1'b0;
      end
      if (bus.issue_valid && !st && bus.issue_rd != 3'd0) np[bus.issue_rd] = 1'b1;
      @(posedge clk);
      m_pend = np;
      #1;
   endtask

   task automatic idle(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
      drive(1'b0, 3'd0, 8'h00, rs, rt, 1'b0, 3'd0);
   endtask

   initial begin
      logic [AW-1:0] a;
      reset = 1'b1;
      idle(3'd0, 3'd0);
      model_reset();
      #12;
      check_outputs("reset_held");
      reset = 1'b0;
      @(posedge clk);
      #1;

      // every index reads zero after reset
      for (int i = 0; i < NR; i++) begin
         a = i[AW-1:0];
         idle(a, 3'(NR - 1 - i));
         #1;
         check("reset_read_rs", {24'd0, bus.rs_data}, 32'h0);
         check("reset_read_rt", {24'd0, bus.rt_data}, 32'h0);
         check("reset_stall",   {31'd0, bus.stall},   32'h0);
      end

      // write to r0 is discarded
      drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b1, 3'd0);
      #1;
      check("r0_bypass", {24'd0, bus.rs_data}, 32'h0);
      clock_edge();
      idle(3'd0, 3'd0);
      #1;
      check("r0_read", {24'd0, bus.rs_data}, 32'h0);
      check("r0_pending", {31'd0, bus.pending[0]}, 32'h0);

      // write r3, bypass in the write cycle, array read afterwards
      drive(1'b1, 3'd3, 8'h0F, 3'd3, 3'd0, 1'b0, 3'd0);
      #1;
      check("r3_bypass", {24'd0, bus.rs_data}, 32'h0F);
      clock_edge();
      idle(3'd3, 3'd0);
      #1;
      check("r3_array", {24'd0, bus.rs_data}, 32'h0F);

      // RAW hazard on r5, resolved by its writeback
      drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd5);
      clock_edge();
      idle(3'd0, 3'd5);
      #1;
      check("haz_pending", {24'd0, bus.pending}, 32'h20);
      check("haz_stall", {31'd0, bus.stall}, 32'h1);
      drive(1'b1, 3'd5, 8'hA5, 3'd0, 3'd5, 1'b0, 3'd0);
      #1;
      check("haz_wb_stall", {31'd0, bus.stall}, 32'h0);
      check("haz_wb_rt", {24'd0, bus.rt_data}, 32'hA5);
      clock_edge();
      idle(3'd0, 3'd0);
      #1;
      check("haz_cleared", {24'd0, bus.pending}, 32'h00);

      // same-edge issue and writeback to r2: set wins, data written
      drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd2);
      clock_edge();
      drive(1'b1, 3'd2, 8'h3C, 3'd0, 3'd0, 1'b1, 3'd2);
      clock_edge();
      idle(3'd2, 3'd0);
      #1;
      check("coll_pending2", {31'd0, bus.pending[2]}, 32'h1);
      check("coll_r2", {24'd0, bus.rs_data}, 32'h3C);
      drive(1'b1, 3'd2, 8'h3C, 3'd0, 3'd0, 1'b0, 3'd0);
      clock_edge();

      // stalled issue must not set the scoreboard
      drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd4);
      clock_edge();
      drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd0, 1'b1, 3'd6);
      #1;
      check("stalled_stall", {31'd0, bus.stall}, 32'h1);
      clock_edge();
      idle(3'd0, 3'd0);
      #1;
      check("stalled_pend6", {31'd0, bus.pending[6]}, 32'h0);
      check("stalled_pend", {24'd0, bus.pending}, 32'h10);
      drive(1'b1, 3'd4, 8'h44, 3'd0, 3'd0, 1'b0, 3'd0);
      clock_edge();

      // async reset mid-run with pending=0x6C and r1=0x11
      drive(1'b1, 3'd1, 8'h11, 3'd0, 3'd0, 1'b1, 3'd2);
      clock_edge();
      drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd3);
      clock_edge();
      drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd5);
      clock_edge();
      drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd6);
      clock_edge();
      idle(3'd1, 3'd0);
      #1;
      check("pre_reset_pending", {24'd0, bus.pending}, 32'h6C);
      check("pre_reset_r1", {24'd0, bus.rs_data}, 32'h11);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("async_pending", {24'd0, bus.pending}, 32'h00);
      check("async_r1", {24'd0, bus.rs_data}, 32'h00);
      // while reset is held, bypass still works but nothing is stored
      drive(1'b1, 3'd1, 8'h55, 3'd1, 3'd0, 1'b1, 3'd3);
      #1;
      check("rst_bypass", {24'd0, bus.rs_data}, 32'h55);
      @(posedge clk);
      #1;
      check("rst_no_pend", {24'd0, bus.pending}, 32'h00);
      idle(3'd1, 3'd0);
      #1;
      check("rst_no_write", {24'd0, bus.rs_data}, 32'h00);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // randomized traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0] rd;
         rd = 3'($urandom_range(0, NR - 1));
         if (m_pend != 8'h00 && $urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 8; k++) begin
               a = 3'($urandom_range(1, NR - 1));
               if (m_pend[a]) begin
                  rd = a;
                  break;
               end
            end
         end
         drive(1'($urandom_range(0, 1)), rd, 8'($urandom),
               3'($urandom_range(0, NR - 1)), 3'($urandom_range(0, NR - 1)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, NR - 1)));
         if ($urandom_range(0, 7) == 0) bus.rt_addr = bus.rs_addr;
         #1;
         check_outputs("rand");
         clock_edge();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
